// File: rtl/johnson_counter_n_if.sv
// Control and status bundle for johnson_counter_n.
// The master drives the control inputs; the counter (slave) returns state and flags.
interface johnson_counter_n_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(2 * WIDTH);

    logic          en;
    logic          up;
    logic          load;
    logic [PW-1:0] load_phase;
    logic          clr_err;
    logic [WIDTH-1:0] q;
    logic [PW-1:0] phase;
    logic          tc;
    logic          err;

    modport master (
        output en, up, load, load_phase, clr_err,
        input  q, phase, tc, err
    );

    modport slave (
        input  en, up, load, load_phase, clr_err,
        output q, phase, tc, err
    );
endinterface

// File: rtl/johnson_counter_n.sv
// Parametrised Johnson (twisted-ring) counter with direction, phase load,
// binary phase decode, terminal-count strobe and self-correction of illegal states.
module johnson_counter_n #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_counter_n_if.slave    io_bus
);
    localparam int PW  = $clog2(2 * WIDTH);
    localparam int MOD = 2 * WIDTH;

    logic [WIDTH-1:0] r_q;
    logic             r_err;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_load_q;
    logic [PW-1:0]    w_phase;
    logic             w_legal;
    logic             w_load_ok;
    logic             w_err_set;
    logic             w_err_nxt;

    // Phase k: top k bits set for k <= WIDTH, else bottom 2*WIDTH-k bits set.
    function automatic logic [WIDTH-1:0] f_enc(input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int j = 0; j < WIDTH; j++) begin
            v[j] = (k <= WIDTH) ? (j >= WIDTH - k) : (j < MOD - k);
        end
        return v;
    endfunction

    // One pass over all phases decodes q and encodes load_phase together.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_legal   = 1'b0;
        w_phase   = '0;
        w_load_ok = 1'b0;
        w_load_q  = '0;
        for (int k = 0; k < MOD; k++) begin
            if (r_q == f_enc(k)) begin
                w_legal = 1'b1;
                w_phase = PW'(k);
            end
            if (io_bus.load_phase == PW'(k)) begin
                w_load_ok = 1'b1;
                w_load_q  = f_enc(k);
            end
        end
    end

    assign w_step_q = io_bus.up ? {~r_q[0], r_q[WIDTH-1:1]}
                                : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};

    // Priority: load, then illegal-state recovery, then count, else hold.
    always_comb begin
        w_q_nxt = r_q;
        if (io_bus.load) begin
            w_q_nxt = w_load_ok ? w_load_q : '0;
        end else if (!w_legal) begin
            w_q_nxt = '0;
        end else if (io_bus.en) begin
            w_q_nxt = w_step_q;
        end
    end

    // A new error in the same cycle wins over clr_err.
    assign w_err_set = io_bus.load ? ~w_load_ok : ~w_legal;

    always_comb begin
        w_err_nxt = r_err;
        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (io_bus.clr_err) begin
            w_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_q   <= '0;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign io_bus.q     = r_q;
    assign io_bus.err   = r_err;
    assign io_bus.phase = w_phase;
    assign io_bus.tc    = io_bus.en & ~io_bus.load & w_legal &
                          ((io_bus.up & (w_phase == PW'(MOD - 1))) |
                           (~io_bus.up & (w_phase == '0)));
endmodule
